// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-set controller: state encoding,
// BCD field limits and the capture range check.
package clock_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SET_HR  = 2'd1,
      SET_MIN = 2'd2,
      COMMIT  = 2'd3
   } state_t;

   localparam logic [3:0] HR_MAX_MS  = 4'd2;
   localparam logic [3:0] HR_MAX_LS  = 4'd3;
   localparam logic [3:0] MIN_MAX_MS = 4'd5;
   localparam logic [3:0] MIN_MAX_LS = 4'd9;

   // True when ms:ls is a legal BCD value not above max_ms:max_ls.
   function automatic logic bcd2_valid(input logic [3:0] ms, input logic [3:0] ls,
                                       input logic [3:0] max_ms, input logic [3:0] max_ls);
      return ((ms < max_ms) && (ls <= 4'd9)) || ((ms == max_ms) && (ls <= max_ls));
   endfunction

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Button, live-time and parallel-load bundle between the debouncers,
// the time-set controller and the clock counter.
interface clock_set_ctrl_if;

   logic       btn_mode;
   logic       btn_inc;
   logic       btn_cancel;
   logic [3:0] time_ms_hr;
   logic [3:0] time_ls_hr;
   logic [3:0] time_ms_min;
   logic [3:0] time_ls_min;
   logic       load;
   logic [3:0] load_ms_hr;
   logic [3:0] load_ls_hr;
   logic [3:0] load_ms_min;
   logic [3:0] load_ls_min;
   logic       editing;
   logic       edit_field;

   modport master (
      output btn_mode, btn_inc, btn_cancel,
      output time_ms_hr, time_ls_hr, time_ms_min, time_ls_min,
      input  load, load_ms_hr, load_ls_hr, load_ms_min, load_ls_min,
      input  editing, edit_field
   );

   modport slave (
      input  btn_mode, btn_inc, btn_cancel,
      input  time_ms_hr, time_ls_hr, time_ms_min, time_ls_min,
      output load, load_ms_hr, load_ls_hr, load_ms_min, load_ls_min,
      output editing, edit_field
   );

endinterface

// File: rtl/clock_set_ctrl_bcd2_inc.sv
// Combinational two-digit BCD increment that wraps to 00 after max_ms:max_ls.
module bcd2_inc (
   input  logic [3:0] ms,
   input  logic [3:0] ls,
   input  logic [3:0] max_ms,
   input  logic [3:0] max_ls,
   output logic [3:0] ms_o,
   output logic [3:0] ls_o
);

   always_comb begin
      ms_o = ms;
      ls_o = ls + 4'd1;
      if ((ms == max_ms) && (ls == max_ls)) begin
         ms_o = 4'd0;
         ls_o = 4'd0;
      end else if (ls == 4'd9) begin
         ms_o = ms + 4'd1;
         ls_o = 4'd0;
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set controller: sequences hour/minute editing from button pulses,
// keeps a shadow time and emits a one-cycle load strobe on commit.
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int TIMEOUT = 30,
   parameter int TW      = 5
) (
   input  logic           clk,
   input  logic           rst,
   clock_set_ctrl_if.slave bus
);

   state_t        state, state_d;
   logic [TW-1:0] cnt, cnt_d;
   logic [3:0]    ms_hr, ls_hr, ms_min, ls_min;
   logic [3:0]    ms_hr_d, ls_hr_d, ms_min_d, ls_min_d;
   logic [3:0]    hr_inc_ms, hr_inc_ls, min_inc_ms, min_inc_ls;
   logic          load_q, editing_q, field_q;
   logic          any_btn;

   bcd2_inc u_hr_inc (
      .ms(ms_hr), .ls(ls_hr), .max_ms(HR_MAX_MS), .max_ls(HR_MAX_LS),
      .ms_o(hr_inc_ms), .ls_o(hr_inc_ls)
   );

   bcd2_inc u_min_inc (
      .ms(ms_min), .ls(ls_min), .max_ms(MIN_MAX_MS), .max_ls(MIN_MAX_LS),
      .ms_o(min_inc_ms), .ls_o(min_inc_ls)
   );

   assign any_btn = bus.btn_mode | bus.btn_inc | bus.btn_cancel;

   always_comb begin
      state_d  = state;
      cnt_d    = cnt;
      ms_hr_d  = ms_hr;
      ls_hr_d  = ls_hr;
      ms_min_d = ms_min;
      ls_min_d = ls_min;
      case (state)
         IDLE: begin
            cnt_d = '0;
            if (bus.btn_mode) begin
               state_d = SET_HR;
               // Out-of-range live fields are captured as 00 so the shadow is always legal.
               if (bcd2_valid(bus.time_ms_hr, bus.time_ls_hr, HR_MAX_MS, HR_MAX_LS)) begin
                  ms_hr_d = bus.time_ms_hr;
                  ls_hr_d = bus.time_ls_hr;
               end else begin
                  ms_hr_d = 4'd0;
                  ls_hr_d = 4'd0;
               end
               if (bcd2_valid(bus.time_ms_min, bus.time_ls_min, MIN_MAX_MS, MIN_MAX_LS)) begin
                  ms_min_d = bus.time_ms_min;
                  ls_min_d = bus.time_ls_min;
               end else begin
                  ms_min_d = 4'd0;
                  ls_min_d = 4'd0;
               end
            end
         end
         SET_HR, SET_MIN: begin
            cnt_d = any_btn ? '0 : cnt + 1'b1;
            if (bus.btn_cancel) begin
               state_d = IDLE;
            end else if (bus.btn_mode) begin
               state_d = (state == SET_HR) ? SET_MIN : COMMIT;
            end else if (bus.btn_inc) begin
               if (state == SET_HR) begin
                  ms_hr_d = hr_inc_ms;
                  ls_hr_d = hr_inc_ls;
               end else begin
                  ms_min_d = min_inc_ms;
                  ls_min_d = min_inc_ls;
               end
            end else if (cnt == TW'(TIMEOUT - 1)) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         COMMIT: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         ms_hr     <= 4'd0;
         ls_hr     <= 4'd0;
         ms_min    <= 4'd0;
         ls_min    <= 4'd0;
         load_q    <= 1'b0;
         editing_q <= 1'b0;
         field_q   <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         ms_hr     <= ms_hr_d;
         ls_hr     <= ls_hr_d;
         ms_min    <= ms_min_d;
         ls_min    <= ls_min_d;
         load_q    <= (state_d == COMMIT);
         editing_q <= (state_d == SET_HR) || (state_d == SET_MIN);
         field_q   <= (state_d == SET_MIN);
      end
   end

   assign bus.load        = load_q;
   assign bus.editing     = editing_q;
   assign bus.edit_field  = field_q;
   assign bus.load_ms_hr  = ms_hr;
   assign bus.load_ls_hr  = ls_hr;
   assign bus.load_ms_min = ms_min;
   assign bus.load_ls_min = ls_min;

endmodule
